// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Shared types and constants for the sequential factorial engine.
//   fact_state_t  : FSM state encoding (IDLE, CALC)
//   FACT_WIDTH    : default result / accumulator width
//   FACT_IN_WIDTH : default operand width
//   max_fit_n()   : largest n whose true n! is below 2**width
// -----------------------------------------------------------------------------
package fact_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } fact_state_t;

  localparam int FACT_WIDTH    = 32;
  localparam int FACT_IN_WIDTH = 8;

  // Largest n with n! < 2**width. The 256-bit scratch value covers widths
  // well beyond anything this engine is expected to be built with.
  function automatic int max_fit_n(input int width);
    logic [255:0] f;
    f = 256'd1;
    for (int k = 2; k < 64; k++) begin
      f = f * 256'(k);
      if ((f >> width) != 256'd0) return k - 1;
    end
    return 63;
  endfunction

endpackage

// File: rtl/fact_if.sv
// -----------------------------------------------------------------------------
// fact_if
// Request/response bundle between a controller (master) and the factorial
// engine (slave).
//   start    : request strobe, master -> slave
//   data     : operand n, master -> slave
//   busy     : computation in progress, slave -> master
//   done     : one-cycle completion pulse, slave -> master
//   fact     : n! modulo 2**WIDTH, slave -> master
//   overflow : true n! did not fit in WIDTH bits, slave -> master
// -----------------------------------------------------------------------------
interface fact_if
  import fact_pkg::*;
#(
  parameter int WIDTH    = FACT_WIDTH,
  parameter int IN_WIDTH = FACT_IN_WIDTH
);

  logic                start;
  logic [IN_WIDTH-1:0] data;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    fact;
  logic                overflow;

  modport master (
    output start, data,
    input  busy, done, fact, overflow
  );

  modport slave (
    input  start, data,
    output busy, done, fact, overflow
  );

endinterface

// File: rtl/fact_mul.sv
// -----------------------------------------------------------------------------
// fact_mul
// Combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
//   i_a, i_b : unsigned operands
//   o_prod   : full-width product
//   o_ovf    : upper WIDTH bits of the product are non-zero
// -----------------------------------------------------------------------------
module fact_mul #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod,
  output logic               o_ovf
);

  // Widen both operands first so the product is computed at full width.
  assign o_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign o_ovf  = |o_prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/fact_engine.sv
// -----------------------------------------------------------------------------
// fact_engine
// Iterative factorial: one multiply per clock, n-1 multiplies for operand n.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : fact_if slave (start, data, busy, done, fact, overflow)
//   o_dbg_state : current FSM state, for observation only
//
// Handshake: start is sampled only in IDLE; the accepting edge captures data.
// busy is high exactly while in CALC. done pulses for the single cycle after
// the terminal edge, when fact/overflow update; they hold until the next
// done. The FSM is already IDLE in the done cycle, so a start there is
// accepted (back-to-back). start during CALC is dropped, not queued.
// -----------------------------------------------------------------------------
module fact_engine
  import fact_pkg::*;
#(
  parameter int WIDTH    = FACT_WIDTH,
  parameter int IN_WIDTH = FACT_IN_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  fact_if.slave       bus,
  output fact_state_t o_dbg_state
);

  fact_state_t r_state;
  fact_state_t w_state_nxt;

  logic [WIDTH-1:0]    r_acc;
  logic [IN_WIDTH-1:0] r_i;
  logic                r_ovf_sticky;
  logic [WIDTH-1:0]    r_fact;
  logic                r_ovf;
  logic                r_done;

  logic [WIDTH-1:0]    w_i_ext;
  logic [2*WIDTH-1:0]  w_prod;
  logic                w_mul_ovf;
  logic                w_last;
  logic                w_accept;
  logic                w_step;
  logic                w_finish;

  // Counter drives the multiplier as an unsigned WIDTH-bit operand.
  assign w_i_ext = WIDTH'(r_i);
  // 0 and 1 both terminate, which makes 0! = 1! = 1 with no multiply.
  assign w_last  = (r_i <= IN_WIDTH'(1));

  fact_mul #(.WIDTH(WIDTH)) u_mul (
    .i_a    (r_acc),
    .i_b    (w_i_ext),
    .o_prod (w_prod),
    .o_ovf  (w_mul_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Overflow is sticky for the whole run; iteration continues regardless so
  // latency depends on n alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_i          <= '0;
      r_ovf_sticky <= 1'b0;
      r_fact       <= '0;
      r_ovf        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_i          <= bus.data;
        r_acc        <= WIDTH'(1);
        r_ovf_sticky <= 1'b0;
      end
      if (w_step) begin
        r_acc        <= w_prod[WIDTH-1:0];
        r_i          <= r_i - IN_WIDTH'(1);
        r_ovf_sticky <= r_ovf_sticky | w_mul_ovf;
      end
      if (w_finish) begin
        r_fact <= r_acc;
        r_ovf  <= r_ovf_sticky;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.busy     = (r_state == CALC);
  assign bus.done     = r_done;
  assign bus.fact     = r_fact;
  assign bus.overflow = r_ovf;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fact_engine.sv
// -----------------------------------------------------------------------------
// tb_fact_engine
// Self-checking bench for fact_engine (WIDTH=32, IN_WIDTH=8): directed
// vector table, hand-written multi-cycle sequences and randomized operands
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fact_engine;
  import fact_pkg::*;

  localparam int W  = 32;
  localparam int IW = 8;

  logic        clk;
  logic        rst_n;
  fact_state_t dbg_state;

  fact_if #(.WIDTH(W), .IN_WIDTH(IW)) bus ();

  fact_engine #(.WIDTH(W), .IN_WIDTH(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // n! mod 2**32 from plain wrapping 32-bit arithmetic.
  function automatic logic [W-1:0] model_fact(input int n);
    logic [W-1:0] r;
    r = 1;
    for (int k = 2; k <= n; k++) r = W'(r * W'(k));
    return r;
  endfunction

  // Largest n whose exact factorial is below 2**32, using 64-bit arithmetic.
  function automatic int model_max_fit();
    longint f;
    int     m;
    f = 1;
    m = 1;
    while (f * (m + 1) < 64'h1_0000_0000) begin
      f = f * (m + 1);
      m++;
    end
    return m;
  endfunction

  function automatic logic model_ovf(input int n);
    return (n > model_max_fit());
  endfunction

  function automatic int model_lat(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive a one-cycle start; returns #1 after the accepting edge.
  task automatic issue(input logic [IW-1:0] n);
    bus.start = 1'b1;
    bus.data  = n;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen (sampled #1 after each edge); busy must be
  // high on every cycle before it and low in the done cycle.
  task automatic wait_done(input bit scramble, output int lat, output logic [W-1:0] f,
                           output logic o, output bit busy_bad, output bit timeout);
    lat      = 0;
    busy_bad = 1'b0;
    timeout  = 1'b0;
    f        = '0;
    o        = 1'b0;
    forever begin
      if (scramble) bus.data = IW'($urandom);
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin
        if (bus.busy) busy_bad = 1'b1;
        f = bus.fact;
        o = bus.overflow;
        break;
      end
      if (!bus.busy) busy_bad = 1'b1;
      if (lat > 400) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int           n;
    logic [W-1:0] f;
    logic         o;
    int           lat;
  } vec_t;

  vec_t vecs[7];

  int           lat;
  logic [W-1:0] f;
  logic         o;
  bit           busy_bad;
  bit           tmo;
  int           extra_done;

  initial begin
    vecs[0] = '{0,  32'd1,          1'b0, 1};
    vecs[1] = '{1,  32'd1,          1'b0, 1};
    vecs[2] = '{2,  32'd2,          1'b0, 2};
    vecs[3] = '{5,  32'd120,        1'b0, 5};
    vecs[4] = '{10, 32'd3628800,    1'b0, 10};
    vecs[5] = '{12, 32'd479001600,  1'b0, 12};
    vecs[6] = '{13, 32'd1932053504, 1'b1, 13};

    bus.start = 1'b0;
    bus.data  = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_fact",     64'(bus.fact),     64'd0);
    check("reset_done",     64'(bus.done),     64'd0);
    check("reset_busy",     64'(bus.busy),     64'd0);
    check("reset_overflow", 64'(bus.overflow), 64'd0);
    check("reset_state",    64'(dbg_state),    64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    check("pkg_max_fit_32", 64'(max_fit_n(32)), 64'(model_max_fit()));

    // Table-driven vectors.
    foreach (vecs[t]) begin
      issue(IW'(vecs[t].n));
      wait_done(1'b0, lat, f, o, busy_bad, tmo);
      check($sformatf("tbl_timeout_n%0d", vecs[t].n), 64'(tmo),      64'd0);
      check($sformatf("tbl_fact_n%0d",    vecs[t].n), 64'(f),        64'(vecs[t].f));
      check($sformatf("tbl_ovf_n%0d",     vecs[t].n), 64'(o),        64'(vecs[t].o));
      check($sformatf("tbl_lat_n%0d",     vecs[t].n), 64'(lat),      64'(vecs[t].lat));
      check($sformatf("tbl_busy_n%0d",    vecs[t].n), 64'(busy_bad), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("tbl_done_pulse_n%0d", vecs[t].n), 64'(bus.done), 64'd0);
      check($sformatf("tbl_fact_hold_n%0d",  vecs[t].n), 64'(bus.fact), 64'(vecs[t].f));
    end

    // Start while busy: second request must be dropped.
    issue(8'd6);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.data  = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(1'b0, lat, f, o, busy_bad, tmo);
    check("busy_start_fact", 64'(f),       64'd720);
    check("busy_start_lat",  64'(lat + 2), 64'd6);
    extra_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done) extra_done++;
    end
    check("busy_start_no_second_done", 64'(extra_done), 64'd0);
    check("busy_start_idle",           64'(bus.busy),   64'd0);

    // Back-to-back: start issued in the done cycle of the previous run.
    issue(8'd3);
    wait_done(1'b0, lat, f, o, busy_bad, tmo);
    check("b2b_first_fact", 64'(f),   64'd6);
    check("b2b_first_lat",  64'(lat), 64'd3);
    issue(8'd4);
    wait_done(1'b0, lat, f, o, busy_bad, tmo);
    check("b2b_second_fact", 64'(f),        64'd24);
    check("b2b_second_lat",  64'(lat),      64'd4);
    check("b2b_second_busy", 64'(busy_bad), 64'd0);

    // Asynchronous reset mid-CALC.
    issue(8'd10);
    repeat (4) @(posedge clk);
    #3;
    check("mid_busy_before_rst", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_busy",  64'(bus.busy),     64'd0);
    check("rst_async_done",  64'(bus.done),     64'd0);
    check("rst_async_fact",  64'(bus.fact),     64'd0);
    check("rst_async_ovf",   64'(bus.overflow), 64'd0);
    check("rst_async_state", 64'(dbg_state),    64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) extra_done++;
    end
    check("rst_discard_no_done", 64'(extra_done), 64'd0);
    issue(8'd3);
    wait_done(1'b0, lat, f, o, busy_bad, tmo);
    check("post_rst_fact", 64'(f),   64'd6);
    check("post_rst_lat",  64'(lat), 64'd3);

    // Randomized operands against the model; data scrambled during CALC.
    for (int r = 0; r < 24; r++) begin
      int n;
      n = (r < 4) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 40));
      exp_q.push_back(model_fact(n));
      issue(IW'(n));
      wait_done(r[0], lat, f, o, busy_bad, tmo);
      check($sformatf("rnd_timeout_n%0d", n), 64'(tmo),              64'd0);
      check($sformatf("rnd_fact_n%0d",    n), 64'(f),                64'(exp_q.pop_front()));
      check($sformatf("rnd_ovf_n%0d",     n), 64'(o),                64'(model_ovf(n)));
      check($sformatf("rnd_lat_n%0d",     n), 64'(lat),              64'(model_lat(n)));
      check($sformatf("rnd_busy_n%0d",    n), 64'(busy_bad),         64'd0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
